// File: rtl/mnist_pkg.sv
// mnist_pkg: shared constants, Q16.16 word type and loader states for the MNIST frame loader.
package mnist_pkg;
  localparam int IMG_PIXELS = 784;
  localparam int Q_ONE_SCALE = 257;
  localparam int NORM_K1 = 834;
  localparam int NORM_K0 = 27801;
  typedef logic signed [31:0] q16_t;
  typedef enum logic [1:0] {FILL, FULL, DRAIN} loader_state_t;
endpackage

// File: rtl/mnist_frame_loader_pixel_to_q16.sv
// pixel_to_q16: combinational pixel to Q16.16 converter.
// MNIST_NORM_EN selects mean/std normalization instead of plain p*257 scaling.
module pixel_to_q16
  import mnist_pkg::*;
#(
  parameter int PIX_BITS = 8
) (
  input  logic [PIX_BITS-1:0] pixel,
  output q16_t                q
);
`ifdef MNIST_NORM_EN
  assign q = q16_t'(32'(pixel) * 32'(NORM_K1)) - q16_t'(NORM_K0);
`else
  assign q = q16_t'(32'(pixel) * 32'(Q_ONE_SCALE));
`endif
endmodule

// File: rtl/mnist_frame_loader.sv
// mnist_frame_loader: byte pixel stream to a held Q16.16 frame buffer for the CNN.
// MNIST_NORM_EN (in pixel_to_q16) switches the converter to normalized output.
module mnist_frame_loader
  import mnist_pkg::*;
#(
  parameter int IMG_H    = 28,
  parameter int IMG_W    = 28,
  parameter int PIX_BITS = 8,
  parameter int BITS     = 31
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [PIX_BITS-1:0]    s_pixel,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic signed [BITS:0]   frame_data [0:IMG_H*IMG_W-1],
  output logic                   frame_valid,
  input  logic                   frame_release,
  output logic                   err_len,
  output logic [15:0]            frame_count
);
  localparam int N = IMG_H * IMG_W;
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  loader_state_t state;
  logic [IW-1:0] idx, p_idx;
  q16_t word, p_word;
  logic p_valid, long_frame, accept;
  assign accept = s_valid && s_ready;
  pixel_to_q16 #(.PIX_BITS(PIX_BITS)) u_conv (.pixel(s_pixel), .q(word));
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= FILL;
      idx <= '0;
      p_idx <= '0;
      p_word <= '0;
      p_valid <= 1'b0;
      long_frame <= 1'b0;
      s_ready <= 1'b0;
      frame_valid <= 1'b0;
      err_len <= 1'b0;
      frame_count <= '0;
      for (int i = 0; i < N; i++) frame_data[i] <= '0;
    end else begin
      p_valid <= accept && state == FILL;
      if (accept && state == FILL) begin
        p_word <= word;
        p_idx <= idx;
      end
      if (p_valid) frame_data[p_idx] <= (BITS + 1)'(p_word);
      // the final word landing is what publishes the frame
      if (p_valid && p_idx == LAST) begin
        frame_valid <= 1'b1;
        frame_count <= frame_count + 16'd1;
      end
      case (state)
        FILL: begin
          s_ready <= 1'b1;
          if (accept) begin
            if (idx == LAST) begin
              state <= FULL;
              s_ready <= 1'b0;
              idx <= '0;
              long_frame <= !s_last;
              err_len <= err_len | !s_last;
            end else if (s_last) begin
              err_len <= 1'b1;
              idx <= '0;
            end else idx <= idx + 1'b1;
          end
        end
        FULL: if (frame_valid && frame_release) begin
          frame_valid <= 1'b0;
          idx <= '0;
          s_ready <= 1'b1;
          state <= long_frame ? DRAIN : FILL;
        end
        DRAIN: begin
          s_ready <= 1'b1;
          if (accept && s_last) begin
            state <= FILL;
            idx <= '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_mnist_frame_loader.sv
// tb_mnist_frame_loader: directed/randomized bench with an array reference model of the frame buffer.
module tb_mnist_frame_loader;
  logic clk = 1'b0, rstn = 1'b0;
  logic [7:0] s_pixel = '0;
  logic s_valid = 1'b0, s_last = 1'b0, frame_release = 1'b0;
  logic s_ready, frame_valid, err_len;
  logic [15:0] frame_count;
  logic signed [31:0] frame_data [0:783];
  logic [31:0] model [0:783];
  int pix [0:783];
  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  mnist_frame_loader dut (
    .clk(clk), .rstn(rstn), .s_pixel(s_pixel), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .frame_data(frame_data), .frame_valid(frame_valid),
    .frame_release(frame_release), .err_len(err_len), .frame_count(frame_count)
  );

  function automatic logic [31:0] conv(input int p);
`ifdef MNIST_NORM_EN
    return 32'(p * 834 - 27801);
`else
    return 32'(p * 257);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_frame(input string tag);
    int first = 0;
    for (int i = 0; i < 784; i++)
      if (frame_data[i] !== model[i]) begin
        first = i;
        break;
      end
    chk($sformatf("%s word[%0d]", tag, first), frame_data[first], model[first]);
  endtask

  task automatic push(input int p, input logic last, input bit gaps);
    int n = 0;
    if (gaps)
      while ($urandom_range(0, 2) == 0) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
    s_valid = 1'b1;
    s_pixel = 8'(p);
    s_last = last;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk("accept_wait", {31'b0, s_ready}, 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic load(input bit gaps, input bit with_last);
    for (int i = 0; i < 784; i++) begin
      push(pix[i], with_last && i == 783, gaps);
      model[i] = conv(pix[i]);
    end
  endtask

  task automatic rand_pix();
    for (int i = 0; i < 784; i++) pix[i] = int'($urandom_range(0, 255));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " s_ready"}, {31'b0, s_ready}, 0);
    chk({tag, " frame_valid"}, {31'b0, frame_valid}, 0);
    chk({tag, " err_len"}, {31'b0, err_len}, 0);
    chk({tag, " frame_count"}, {16'b0, frame_count}, 0);
    for (int i = 0; i < 784; i++) model[i] = '0;
    check_frame({tag, " data"});
  endtask

  task automatic release_pulse();
    frame_release = 1'b1;
    @(negedge clk);
    frame_release = 1'b0;
  endtask

  initial begin
    #12;
    check_reset("por");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'b0, s_ready}, 1);

    for (int i = 0; i < 784; i++) pix[i] = i % 256;
    load(1'b1, 1'b1);
    chk("fv_before_last_write", {31'b0, frame_valid}, 0);
    chk("ready_drop", {31'b0, s_ready}, 0);
    @(negedge clk);
    chk("fv_full", {31'b0, frame_valid}, 1);
    chk("count1", {16'b0, frame_count}, 1);
    chk("err_clean", {31'b0, err_len}, 0);
    check_frame("ramp");
`ifdef MNIST_NORM_EN
    chk("norm_p0", frame_data[0], 32'hFFFF9367);
    chk("norm_p255", frame_data[255], 32'd184869);
`else
    chk("word0", frame_data[0], 32'd0);
    chk("word255", frame_data[255], 32'd65535);
    chk("word783", frame_data[783], 32'd3855);
`endif
    s_valid = 1'b1;
    s_pixel = 8'($urandom);
    repeat (5) begin
      @(negedge clk);
      chk("ready_in_full", {31'b0, s_ready}, 0);
    end
    s_valid = 1'b0;
    check_frame("full_stable");
    chk("fv_held", {31'b0, frame_valid}, 1);

    release_pulse();
    chk("fv_release", {31'b0, frame_valid}, 0);
    chk("ready_release", {31'b0, s_ready}, 1);

    for (int i = 0; i < 784; i++) pix[i] = 255;
    load(1'b0, 1'b1);
    @(negedge clk);
    chk("fv_b2b", {31'b0, frame_valid}, 1);
    chk("count2", {16'b0, frame_count}, 2);
    check_frame("all255");
    frame_release = 1'b1;
    repeat (3) @(negedge clk);
    frame_release = 1'b0;
    chk("held_release_fv", {31'b0, frame_valid}, 0);
    chk("held_release_ready", {31'b0, s_ready}, 1);
    chk("held_release_count", {16'b0, frame_count}, 2);

    rstn = 1'b0;
    #1;
    check_reset("rst2");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    rand_pix();
    for (int i = 0; i <= 10; i++) begin
      push(pix[i], i == 10, 1'b1);
      model[i] = conv(pix[i]);
    end
    repeat (2) @(negedge clk);
    chk("short_err", {31'b0, err_len}, 1);
    chk("short_fv", {31'b0, frame_valid}, 0);
    chk("short_ready", {31'b0, s_ready}, 1);
    check_frame("short");
    rand_pix();
    load(1'b1, 1'b1);
    @(negedge clk);
    chk("after_short_fv", {31'b0, frame_valid}, 1);
    chk("after_short_count", {16'b0, frame_count}, 1);
    check_frame("after_short");
    release_pulse();

    rand_pix();
    load(1'b0, 1'b0);
    @(negedge clk);
    chk("long_fv", {31'b0, frame_valid}, 1);
    chk("long_err", {31'b0, err_len}, 1);
    chk("long_count", {16'b0, frame_count}, 2);
    check_frame("long");
    release_pulse();
    chk("drain_ready", {31'b0, s_ready}, 1);
    chk("drain_fv", {31'b0, frame_valid}, 0);
    for (int i = 0; i < 5; i++) push(int'($urandom_range(0, 255)), i == 4, 1'b0);
    repeat (2) @(negedge clk);
    chk("drain_done_fv", {31'b0, frame_valid}, 0);
    check_frame("drain_discard");
    rand_pix();
    load(1'b0, 1'b1);
    @(negedge clk);
    chk("post_drain_fv", {31'b0, frame_valid}, 1);
    chk("post_drain_count", {16'b0, frame_count}, 3);
    check_frame("post_drain");
    release_pulse();

    rand_pix();
    for (int i = 0; i < 400; i++) push(pix[i], 1'b0, 1'b1);
    rstn = 1'b0;
    #1;
    check_reset("mid_rst");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    rand_pix();
    load(1'b1, 1'b1);
    @(negedge clk);
    chk("post_rst_fv", {31'b0, frame_valid}, 1);
    chk("post_rst_count", {16'b0, frame_count}, 1);
    chk("post_rst_err", {31'b0, err_len}, 0);
    check_frame("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
